nw_job_sched: RTL and testbench

Round-robin scheduler that shares one Needleman-Wunsch scoring grid among NREQ requesters. It accepts an alignment job (string pair) from one requester at a time and drives the pair onto the grid. It holds the grid in reset while loading, releases it, and waits for grid valid. It then returns the score, tagged with the requester index, over a valid/ready response channel.

---
 rtl/nw_job_sched_if.sv | 47 ++++
 rtl/nw_job_sched.sv | 194 +++++++++++++++++++
 tb/tb_nw_job_sched.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nw_job_sched_if.sv
// nw_job_sched_if: groups the scheduler's requester, grid and response signals.
// The master modport is the scheduler; the slave modport is everything around it
// (requesters, the scoring grid and the response consumer).
// rsp_err exists only when NW_SCHED_WATCHDOG_EN is defined.
interface nw_job_sched_if #(
    parameter int NREQ   = 4,
    parameter int LENGTH = 10,
    parameter int CWIDTH = 2,
    parameter int SWIDTH = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW  = LENGTH * CWIDTH;

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*SW-1:0]       req_s1;
    logic [NREQ*SW-1:0]       req_s2;
    logic                     grid_rst;
    logic [SW-1:0]            grid_s1;
    logic [SW-1:0]            grid_s2;
    logic signed [SWIDTH-1:0] grid_score;
    logic                     grid_valid;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDW-1:0]           rsp_id;
    logic signed [SWIDTH-1:0] rsp_score;
    logic                     busy;
`ifdef NW_SCHED_WATCHDOG_EN
    logic                     rsp_err;
`endif

    modport master (
        input  req_valid, req_s1, req_s2, grid_score, grid_valid, rsp_ready,
        output req_ready, grid_rst, grid_s1, grid_s2, rsp_valid, rsp_id, rsp_score, busy
`ifdef NW_SCHED_WATCHDOG_EN
        , output rsp_err
`endif
    );

    modport slave (
        output req_valid, req_s1, req_s2, grid_score, grid_valid, rsp_ready,
        input  req_ready, grid_rst, grid_s1, grid_s2, rsp_valid, rsp_id, rsp_score, busy
`ifdef NW_SCHED_WATCHDOG_EN
        , input rsp_err
`endif
    );
endinterface

// File: rtl/nw_job_sched.sv
// nw_job_sched: round-robin scheduler sharing one Needleman-Wunsch scoring grid
// among NREQ requesters. A granted job's string pair is latched onto the grid,
// the grid is held in reset for RST_CYCLES, released, and its score is returned
// tagged with the requester index over a valid/ready response channel.
// Optional feature macro: NW_SCHED_WATCHDOG_EN (adds rsp_err and a RUN timeout
// of MAX_CYCLES cycles that returns a zero score with rsp_err=1).
module nw_job_sched #(
    parameter int NREQ       = 4,
    parameter int LENGTH     = 10,
    parameter int CWIDTH     = 2,
    parameter int SWIDTH     = 16,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    nw_job_sched_if.master     bus
);
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW      = LENGTH * CWIDTH;
    localparam int CNT_MAX = (MAX_CYCLES > RST_CYCLES) ? MAX_CYCLES : RST_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_SAT  = {CW{1'b1}};
    localparam logic [CW-1:0]  RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [IDW-1:0] ID_ZERO  = {IDW{1'b0}};
    localparam logic [IDW-1:0] ID_ONE   = IDW'(1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);
    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
`ifdef NW_SCHED_WATCHDOG_EN
    localparam logic [CW-1:0]  WD_LAST  = CW'(MAX_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                   state_r;
    logic [IDW-1:0]           rr_ptr_r;
    logic [IDW-1:0]           job_id_r;
    logic [CW-1:0]            cnt_r;
    logic [SW-1:0]            grid_s1_r;
    logic [SW-1:0]            grid_s2_r;
    logic                     grid_rst_r;
    logic                     rsp_valid_r;
    logic [IDW-1:0]           rsp_id_r;
    logic signed [SWIDTH-1:0] rsp_score_r;
    logic                     busy_r;
`ifdef NW_SCHED_WATCHDOG_EN
    logic                     rsp_err_r;
`endif

    logic [IDW:0]             sum_s;
    logic [IDW:0]             cand_s;
    logic [IDW-1:0]           grant_idx_s;
    logic                     grant_any_s;
    logic [NREQ-1:0]          req_ready_s;
    logic [IDW-1:0]           rr_next_s;

    // Round-robin search: the candidate closest to rr_ptr (with wrap) wins, so
    // the loop runs from the farthest offset down and the last hit sticks.
    always_comb begin
        grant_idx_s = ID_ZERO;
        grant_any_s = 1'b0;
        sum_s       = {(IDW+1){1'b0}};
        cand_s      = {(IDW+1){1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum_s  = {1'b0, rr_ptr_r} + (IDW+1)'(k);
            cand_s = (sum_s >= NREQ_W) ? (sum_s - NREQ_W) : sum_s;
            if (bus.req_valid[cand_s[IDW-1:0]]) begin
                grant_idx_s = cand_s[IDW-1:0];
                grant_any_s = 1'b1;
            end else begin
                grant_idx_s = grant_idx_s;
                grant_any_s = grant_any_s;
            end
        end
    end

    // One-hot grant, offered only while idle; also the pointer that follows it.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        rr_next_s   = (grant_idx_s == ID_LAST) ? ID_ZERO : (grant_idx_s + ID_ONE);
        if ((state_r == IDLE) && grant_any_s) begin
            req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // Job FSM: accept, hold grid in reset, run the grid, then hold the response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= ID_ZERO;
            job_id_r    <= ID_ZERO;
            cnt_r       <= CNT_ZERO;
            grid_s1_r   <= {SW{1'b0}};
            grid_s2_r   <= {SW{1'b0}};
            grid_rst_r  <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= ID_ZERO;
            rsp_score_r <= {SWIDTH{1'b0}};
            busy_r      <= 1'b0;
`ifdef NW_SCHED_WATCHDOG_EN
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        grid_s1_r <= bus.req_s1[grant_idx_s*SW +: SW];
                        grid_s2_r <= bus.req_s2[grant_idx_s*SW +: SW];
                        job_id_r  <= grant_idx_s;
                        rr_ptr_r  <= rr_next_s;
                        cnt_r     <= CNT_ZERO;
                        busy_r    <= 1'b1;
                        state_r   <= LOAD;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                LOAD: begin
                    if (cnt_r == RST_LAST) begin
                        cnt_r      <= CNT_ZERO;
                        grid_rst_r <= 1'b0;
                        state_r    <= RUN;
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                    end
                end
                RUN: begin
                    if (bus.grid_valid) begin
                        rsp_score_r <= bus.grid_score;
                        rsp_id_r    <= job_id_r;
                        rsp_valid_r <= 1'b1;
`ifdef NW_SCHED_WATCHDOG_EN
                        rsp_err_r   <= 1'b0;
`endif
                        state_r     <= RESP;
                    end
`ifdef NW_SCHED_WATCHDOG_EN
                    else if (cnt_r == WD_LAST) begin
                        rsp_score_r <= {SWIDTH{1'b0}};
                        rsp_id_r    <= job_id_r;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        state_r     <= RESP;
                    end
`endif
                    else begin
                        cnt_r <= (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CNT_ONE);
                    end
                end
                RESP: begin
                    // Grid stays out of reset so its result is not disturbed
                    // while the consumer stalls.
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        grid_rst_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    grid_rst_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.grid_rst  = grid_rst_r;
    assign bus.grid_s1   = grid_s1_r;
    assign bus.grid_s2   = grid_s2_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_score = rsp_score_r;
    assign bus.busy      = busy_r;
`ifdef NW_SCHED_WATCHDOG_EN
    assign bus.rsp_err   = rsp_err_r;
`endif

endmodule

// File: tb/tb_nw_job_sched.sv
// tb_nw_job_sched: directed bench for nw_job_sched with a behavioural grid,
// a grant queue and a response scoreboard. Watchdog steps run only when
// NW_SCHED_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_nw_job_sched;
    localparam int NREQ       = 4;
    localparam int LENGTH     = 10;
    localparam int CWIDTH     = 2;
    localparam int SWIDTH     = 16;
    localparam int RST_CYCLES = 2;
    localparam int MAX_CYCLES = 64;
    localparam int SW         = LENGTH * CWIDTH;

    typedef struct {
        logic [1:0]         id;
        logic signed [15:0] score;
        logic               err;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   grid_lat = 3;
    int   gcnt = 0;
    int   n;
    rsp_t rsp_q [$];
    int   grant_q [$];
    logic [SW-1:0] s1_tab [NREQ];
    logic [SW-1:0] s2_tab [NREQ];

    always #5 clk = ~clk;

    nw_job_sched_if #(.NREQ(NREQ), .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH)) bus ();

    nw_job_sched #(
        .NREQ(NREQ), .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH),
        .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Global alignment score: match +1, mismatch -1, gap -1; character 0 in MSBs.
    function automatic logic signed [15:0] nw(input logic [SW-1:0] a, input logic [SW-1:0] b);
        int h [0:LENGTH][0:LENGTH];
        int d;
        for (int i = 0; i <= LENGTH; i++) begin
            h[i][0] = -i;
            h[0][i] = -i;
        end
        for (int i = 1; i <= LENGTH; i++) begin
            for (int j = 1; j <= LENGTH; j++) begin
                d = h[i-1][j-1] + ((a[(LENGTH-i)*CWIDTH +: CWIDTH] == b[(LENGTH-j)*CWIDTH +: CWIDTH]) ? 1 : -1);
                if (h[i-1][j] - 1 > d) d = h[i-1][j] - 1;
                if (h[i][j-1] - 1 > d) d = h[i][j-1] - 1;
                h[i][j] = d;
            end
        end
        return 16'(h[LENGTH][LENGTH]);
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push_rsp(input int id, input logic signed [15:0] score, input logic err);
        rsp_t e;
        e.id    = 2'(id);
        e.score = score;
        e.err   = err;
        rsp_q.push_back(e);
    endtask

    // Wait (bounded) for a grant to requester g; returns at the negedge it shows.
    task automatic wait_grant(input int g, input string tag);
        int k = 0;
        @(negedge clk); #1;
        while (bus.req_ready[g] !== 1'b1 && k < 200) begin
            k++;
            @(negedge clk); #1;
        end
        check(tag, {31'b0, bus.req_ready[g]}, 32'd1);
    endtask

    // Wait (bounded) until every expected response has been seen and the DUT is idle.
    task automatic drain(input string tag);
        int k = 0;
        while ((rsp_q.size() != 0 || bus.busy !== 1'b0) && k < 2000) begin
            k++;
            @(negedge clk); #1;
        end
        check({tag, "_rsp"}, rsp_q.size(), 32'd0);
        check({tag, "_idle"}, {31'b0, bus.busy}, 32'd0);
    endtask

    // Behavioural grid: score appears grid_lat cycles after grid_rst drops, sticky until reset.
    always @(posedge clk) begin
        if (bus.grid_rst === 1'b1) begin
            bus.grid_valid <= 1'b0;
            bus.grid_score <= 16'sd0;
            gcnt           <= 0;
        end else if (gcnt >= grid_lat) begin
            bus.grid_valid <= 1'b1;
            bus.grid_score <= nw(bus.grid_s1, bus.grid_s2);
        end else begin
            gcnt <= gcnt + 1;
        end
    end

    // Monitor: score grants and completed responses against the expectation queues.
    always @(negedge clk) begin
        rsp_t e;
        if (reset) begin
            if ((bus.req_valid & bus.req_ready) != 4'b0000) begin
                check("grant_onehot", $countones(bus.req_ready), 32'd1);
                check("grant_not_busy", {31'b0, bus.busy}, 32'd0);
                if (grant_q.size() != 0) check("grant_id", onehot_idx(bus.req_ready), grant_q.pop_front());
                else check("grant_unexpected", {28'b0, bus.req_ready}, 32'd0);
            end
            if (bus.busy && bus.req_valid != 4'b0000) check("ready_while_busy", {28'b0, bus.req_ready}, 32'd0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    check("rsp_id", {30'b0, bus.rsp_id}, {30'b0, e.id});
                    check("rsp_score", {16'b0, bus.rsp_score}, {16'b0, e.score});
`ifdef NW_SCHED_WATCHDOG_EN
                    check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
`endif
                end else begin
                    check("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
                end
            end
        end
    end

    initial begin
        s1_tab[0] = 20'h00000; s2_tab[0] = 20'h55555;
        s1_tab[1] = 20'h2C4E1; s2_tab[1] = 20'h2C4E3;
        s1_tab[2] = 20'h1B1B1; s2_tab[2] = 20'h1B1B1;
        s1_tab[3] = 20'h3A5F0; s2_tab[3] = 20'h0F3A5;
        bus.req_s1    = {s1_tab[3], s1_tab[2], s1_tab[1], s1_tab[0]};
        bus.req_s2    = {s2_tab[3], s2_tab[2], s2_tab[1], s2_tab[0]};
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {28'b0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_id", {30'b0, bus.rsp_id}, 32'd0);
        check("rst_rsp_score", {16'b0, bus.rsp_score}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_grid_s1", {12'b0, bus.grid_s1}, 32'd0);
        check("rst_grid_s2", {12'b0, bus.grid_s2}, 32'd0);
        check("rst_grid_rst", {31'b0, bus.grid_rst}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.rsp_ready = 1'b1;

        // Identical strings on requester 2
        grant_q.push_back(2);
        push_rsp(2, 16'sd10, 1'b0);
        bus.req_valid = 4'b0100;
        wait_grant(2, "t1_grant");
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("t1_ready_one_cycle", {28'b0, bus.req_ready}, 32'd0);
        check("t1_grid_s1", {12'b0, bus.grid_s1}, {12'b0, 20'h1B1B1});
        check("t1_grid_s2", {12'b0, bus.grid_s2}, {12'b0, 20'h1B1B1});
        n = 0;
        while (bus.grid_rst === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t1_grid_rst_cycles", n, RST_CYCLES);
        drain("t1");

        // All mismatch on requester 0
        grant_q.push_back(0);
        push_rsp(0, 16'shFFF6, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 4'b0001;
        wait_grant(0, "t2_grant");
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        check("t2_grid_s2", {12'b0, bus.grid_s2}, {12'b0, 20'h55555});
        drain("t2");

        // Round robin after reset, all requesters continuously valid
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            grant_q.push_back(i % NREQ);
            push_rsp(i % NREQ, nw(s1_tab[i % NREQ], s2_tab[i % NREQ]), 1'b0);
        end
        bus.req_valid = 4'b1111;
        n = 0;
        while (grant_q.size() != 0 && n < 500) begin
            n++;
            @(negedge clk); #1;
        end
        check("rr_all_granted", grant_q.size(), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        drain("rr");

        // Backpressure: job for 3, requester 1 pending while response is stalled
        bus.rsp_ready = 1'b0;
        grant_q.push_back(3);
        grant_q.push_back(1);
        push_rsp(3, nw(s1_tab[3], s2_tab[3]), 1'b0);
        push_rsp(1, nw(s1_tab[1], s2_tab[1]), 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 4'b1000;
        wait_grant(3, "bp_grant3");
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("bp_rsp_valid_seen", {31'b0, bus.rsp_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
            check("bp_hold_id", {30'b0, bus.rsp_id}, 32'd3);
            check("bp_hold_score", {16'b0, bus.rsp_score}, {16'b0, nw(s1_tab[3], s2_tab[3])});
            check("bp_no_grant", {28'b0, bus.req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_no_grant_hs", {28'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("bp_grant1_after", {28'b0, bus.req_ready}, 32'd2);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        drain("bp");

        // Reset mid-run: requester 1 job aborted, pointer back to 0
        grant_q.push_back(1);
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        wait_grant(1, "mr_grant1");
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        n = 0;
        while (bus.grid_rst !== 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("mr_in_run", {31'b0, bus.grid_rst}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("mr_grid_rst", {31'b0, bus.grid_rst}, 32'd1);
        check("mr_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check("mr_busy", {31'b0, bus.busy}, 32'd0);
        repeat (10) @(negedge clk);
        check("mr_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        grant_q.push_back(0);
        push_rsp(0, nw(s1_tab[0], s2_tab[0]), 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;
        wait_grant(0, "mr_grant0");
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        drain("mr");

`ifdef NW_SCHED_WATCHDOG_EN
        // Watchdog: grid never completes
        grid_lat = 1000000;
        grant_q.push_back(1);
        push_rsp(1, 16'sd0, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 4'b0010;
        wait_grant(1, "wd_grant");
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        n = 0;
        while (bus.grid_rst !== 1'b0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("wd_run_cycles", n, MAX_CYCLES);
        check("wd_err_flag", {31'b0, bus.rsp_err}, 32'd1);
        drain("wd");
        grid_lat = 3;
`endif

        check("end_grant_q", grant_q.size(), 32'd0);
        check("end_rsp_q", rsp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
